// File: rtl/riscv_ooo_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ooo_types_pkg
// Description : Shared types for the out-of-order core's reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ooo_types_pkg;

    localparam int c_XLEN_MAX = 64;
    localparam int c_REG_W    = 5;

    typedef logic [3:0] exception_code_t;

    // Retire lane payload, sized for the widest XLEN; narrower cores zero-extend.
    typedef struct packed {
        logic [c_XLEN_MAX-1:0] pc;
        logic [c_REG_W-1:0]    dest;
        logic                  has_dest;
        logic [c_XLEN_MAX-1:0] result;
        logic                  exc;
        exception_code_t       exc_code;
    } rob_ret_t;

    localparam logic [1:0] c_ENT_FREE   = 2'd0;
    localparam logic [1:0] c_ENT_ISSUED = 2'd1;
    localparam logic [1:0] c_ENT_DONE   = 2'd2;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_retire_select.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire_select
// Description : Contiguous retire-lane selection from the entries at head.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_retire_select #(
    parameter int RET_W = 2
) (
    input  logic [RET_W-1:0] i_done,
    input  logic [RET_W-1:0] i_exc,
    output logic [RET_W-1:0] o_valid
);

    logic w_run;

    // An excepting entry only ever retires alone in lane 0, so an exc at head
    // or at any younger lane stops the run.
    always_comb begin
        w_run   = 1'b0;
        o_valid = '0;
        for (int j = 0; j < RET_W; j++) begin
            if (j == 0) begin
                w_run = i_done[0];
            end else begin
                w_run = w_run && i_done[j] && !i_exc[j] && !i_exc[0];
            end
            o_valid[j] = w_run;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_multi_port.sv
`default_nettype none
// ============================================================================
// Module      : rob_multi_port
// Description : Multi-port reorder buffer: wide dispatch, multi-port
//               completion, in-order contiguous multi-lane retire.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_multi_port
    import riscv_ooo_types_pkg::*;
#(
    parameter int ROB_SIZE = 32,
    parameter int XLEN     = 32,
    parameter int DISP_W   = 2,
    parameter int CMPL_W   = 3,
    parameter int RET_W    = 2
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        flush_i,
    input  logic [DISP_W-1:0]                           disp_valid_i,
    input  logic [DISP_W-1:0][XLEN-1:0]                 disp_pc_i,
    input  logic [DISP_W-1:0][c_REG_W-1:0]              disp_dest_i,
    input  logic [DISP_W-1:0]                           disp_has_dest_i,
    output logic                                        disp_ready_o,
    output logic [DISP_W-1:0][$clog2(ROB_SIZE)-1:0]     disp_idx_o,
    input  logic [CMPL_W-1:0]                           cmpl_valid_i,
    input  logic [CMPL_W-1:0][$clog2(ROB_SIZE)-1:0]     cmpl_idx_i,
    input  logic [CMPL_W-1:0][XLEN-1:0]                 cmpl_result_i,
    input  logic [CMPL_W-1:0]                           cmpl_exc_i,
    input  exception_code_t [CMPL_W-1:0]                cmpl_exc_code_i,
    output logic [RET_W-1:0]                            ret_valid_o,
    output rob_ret_t [RET_W-1:0]                        ret_entry_o,
    input  logic                                        ret_ready_i,
    output logic                                        exc_flush_o,
    output logic [$clog2(ROB_SIZE):0]                   count_o,
    output logic                                        full_o,
    output logic                                        empty_o
);

    localparam int                 c_IDX_W     = $clog2(ROB_SIZE);
    localparam int                 c_CNT_W     = c_IDX_W + 1;
    localparam logic [c_CNT_W-1:0] c_READY_MAX = c_CNT_W'(ROB_SIZE - DISP_W);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT  = c_CNT_W'(ROB_SIZE);

    logic [1:0]            r_state    [ROB_SIZE];
    logic [XLEN-1:0]       r_pc       [ROB_SIZE];
    logic [c_REG_W-1:0]    r_dest     [ROB_SIZE];
    logic                  r_has_dest [ROB_SIZE];
    logic [XLEN-1:0]       r_result   [ROB_SIZE];
    logic                  r_exc      [ROB_SIZE];
    exception_code_t       r_exc_code [ROB_SIZE];

    logic [c_IDX_W-1:0]    r_head;
    logic [c_IDX_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_exc_flush;

    logic                  w_disp_fire;
    logic [c_CNT_W-1:0]    w_num_disp;
    logic [c_CNT_W-1:0]    w_num_ret;
    logic                  w_ret_fire;
    logic                  w_exc_accept;
    logic [CMPL_W-1:0]     w_cmpl_win;
    logic [RET_W-1:0]      w_head_done;
    logic [RET_W-1:0]      w_head_exc;
    logic [RET_W-1:0]      w_ret_valid;
    logic [RET_W-1:0][c_IDX_W-1:0] w_ret_idx;

    // Readiness uses the pre-retire count so it never depends on ret_ready_i.
    assign disp_ready_o = (r_count <= c_READY_MAX);
    assign w_disp_fire  = disp_ready_o && (|disp_valid_i);
    assign w_num_disp   = w_disp_fire ? c_CNT_W'(popcnt4(4'(disp_valid_i))) : '0;

    assign w_ret_fire   = ret_ready_i && w_ret_valid[0];
    assign w_num_ret    = w_ret_fire ? c_CNT_W'(popcnt4(4'(w_ret_valid))) : '0;
    assign w_exc_accept = w_ret_fire && r_exc[r_head];

    genvar k;
    generate
        for (k = 0; k < DISP_W; k++) begin : g_disp_idx
            assign disp_idx_o[k] = r_tail + c_IDX_W'(k);
        end
    endgenerate

    // Only ISSUED entries accept completion; among colliding ports the lowest wins.
    always_comb begin
        w_cmpl_win = '0;
        for (int p = 0; p < CMPL_W; p++) begin
            w_cmpl_win[p] = cmpl_valid_i[p] && (r_state[cmpl_idx_i[p]] == c_ENT_ISSUED);
            for (int q = 0; q < p; q++) begin
                if (cmpl_valid_i[q] && (cmpl_idx_i[q] == cmpl_idx_i[p])) begin
                    w_cmpl_win[p] = 1'b0;
                end
            end
        end
    end

    genvar j;
    generate
        for (j = 0; j < RET_W; j++) begin : g_ret_lane
            assign w_ret_idx[j]   = r_head + c_IDX_W'(j);
            assign w_head_done[j] = (r_state[w_ret_idx[j]] == c_ENT_DONE);
            assign w_head_exc[j]  = r_exc[w_ret_idx[j]];

            always_comb begin
                ret_entry_o[j]          = '0;
                ret_entry_o[j].pc       = c_XLEN_MAX'(r_pc[w_ret_idx[j]]);
                ret_entry_o[j].dest     = r_dest[w_ret_idx[j]];
                ret_entry_o[j].has_dest = r_has_dest[w_ret_idx[j]];
                ret_entry_o[j].result   = c_XLEN_MAX'(r_result[w_ret_idx[j]]);
                ret_entry_o[j].exc      = r_exc[w_ret_idx[j]];
                ret_entry_o[j].exc_code = r_exc_code[w_ret_idx[j]];
            end
        end
    endgenerate

    rob_retire_select #(
        .RET_W   (RET_W)
    ) u_retire_select (
        .i_done  (w_head_done),
        .i_exc   (w_head_exc),
        .o_valid (w_ret_valid)
    );

    assign ret_valid_o = w_ret_valid;

    // Payload carries no reset: an entry is only observed once its state says so.
    always_ff @(posedge clk_i) begin
        if (w_disp_fire) begin
            for (int d = 0; d < DISP_W; d++) begin
                if (disp_valid_i[d]) begin
                    r_pc[disp_idx_o[d]]       <= disp_pc_i[d];
                    r_dest[disp_idx_o[d]]     <= disp_dest_i[d];
                    r_has_dest[disp_idx_o[d]] <= disp_has_dest_i[d];
                end
            end
        end
        for (int p = 0; p < CMPL_W; p++) begin
            if (w_cmpl_win[p]) begin
                r_result[cmpl_idx_i[p]]   <= cmpl_result_i[p];
                r_exc[cmpl_idx_i[p]]      <= cmpl_exc_i[p];
                r_exc_code[cmpl_idx_i[p]] <= cmpl_exc_code_i[p];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_state[i] <= c_ENT_FREE;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_exc_flush <= 1'b0;
        end else begin
            r_exc_flush <= w_exc_accept && !flush_i;
            if (flush_i || w_exc_accept) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    r_state[i] <= c_ENT_FREE;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                // Retire, completion and dispatch touch disjoint entries (DONE,
                // ISSUED and FREE respectively), so ordering here is irrelevant.
                for (int r = 0; r < RET_W; r++) begin
                    if (w_ret_fire && w_ret_valid[r]) begin
                        r_state[w_ret_idx[r]] <= c_ENT_FREE;
                    end
                end
                for (int p = 0; p < CMPL_W; p++) begin
                    if (w_cmpl_win[p]) begin
                        r_state[cmpl_idx_i[p]] <= c_ENT_DONE;
                    end
                end
                if (w_disp_fire) begin
                    for (int d = 0; d < DISP_W; d++) begin
                        if (disp_valid_i[d]) begin
                            r_state[disp_idx_o[d]] <= c_ENT_ISSUED;
                        end
                    end
                end
                r_head  <= r_head + w_num_ret[c_IDX_W-1:0];
                r_tail  <= r_tail + w_num_disp[c_IDX_W-1:0];
                r_count <= r_count + w_num_disp - w_num_ret;
            end
        end
    end

    assign exc_flush_o = r_exc_flush;
    assign count_o     = r_count;
    assign full_o      = (r_count == c_FULL_CNT);
    assign empty_o     = (r_count == '0);

endmodule
`default_nettype wire
